ps2_scan_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_scan_rx_filter.sv | 59 +++++
 rtl/ps2_scan_rx.sv | 168 ++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] KEY_SPACE = 8'h29;

endpackage

// File: rtl/ps2_scan_rx_filter.sv
// ps2_line_filter: 2-flop synchroniser plus a stability filter on one raw line.
// The filtered level moves only after FILTER_LEN consecutive disagreeing samples;
// o_fall pulses for one cycle in the cycle the filtered level becomes 0.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Synchronise the asynchronous line; idle-high reset value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Count consecutive samples that disagree with the filtered level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_s2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_s2;
          r_cnt   <= '0;
          r_fall  <= ~r_s2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host frame receiver feeding the game core.
// Optional feature macro: PS2_BREAK_FILTER_EN (suppress break/extended sequences
// so only make codes produce valid).
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboard,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  logic             w_clk_lvl;
  logic             w_clk_fall;
  logic             w_edge;
  logic             r_data_s1;
  logic             r_data_s2;

  ps2_state_t       r_state,     w_state_n;
  logic [2:0]       r_bit_cnt,   w_bit_cnt_n;
  logic [7:0]       r_shift,     w_shift_n;
  logic             r_par,       w_par_n;
  logic [TMO_W-1:0] r_tmo,       w_tmo_n;
  logic [7:0]       r_keyboard,  w_keyboard_n;
  logic             r_valid,     w_valid_n;
  logic             r_frame_err, w_frame_err_n;
`ifdef PS2_BREAK_FILTER_EN
  logic             r_brk,       w_brk_n;
`endif

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (ps2_clk),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  // A fall pulse always coincides with a low filtered level
  assign w_edge = w_clk_fall & ~w_clk_lvl;

  // Plain synchroniser for the data line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
    end else begin
      r_data_s1 <= ps2_data;
      r_data_s2 <= r_data_s1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_tmo       <= '0;
      r_keyboard  <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      r_brk       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_shift     <= w_shift_n;
      r_par       <= w_par_n;
      r_tmo       <= w_tmo_n;
      r_keyboard  <= w_keyboard_n;
      r_valid     <= w_valid_n;
      r_frame_err <= w_frame_err_n;
`ifdef PS2_BREAK_FILTER_EN
      r_brk       <= w_brk_n;
`endif
    end
  end

  // Frame decode on filtered falling edges; timeout abandons stalled frames
  always_comb begin
    w_state_n     = r_state;
    w_bit_cnt_n   = r_bit_cnt;
    w_shift_n     = r_shift;
    w_par_n       = r_par;
    w_tmo_n       = r_tmo;
    w_keyboard_n  = r_keyboard;
    w_valid_n     = 1'b0;
    w_frame_err_n = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    w_brk_n       = r_brk;
`endif
    if (w_edge) begin
      w_tmo_n = '0;
      case (r_state)
        IDLE: begin
          if (!r_data_s2) begin
            w_state_n   = DATA;
            w_bit_cnt_n = '0;
          end
        end
        DATA: begin
          w_shift_n   = {r_data_s2, r_shift[7:1]};
          w_bit_cnt_n = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_n = PARITY;
          end
        end
        PARITY: begin
          w_par_n   = r_data_s2;
          w_state_n = STOP;
        end
        STOP: begin
          w_state_n = IDLE;
          if (r_data_s2 && ((^r_shift) ^ r_par)) begin
`ifdef PS2_BREAK_FILTER_EN
            if (r_shift == PS2_BREAK) begin
              w_brk_n = 1'b1;
            end else if (r_shift == PS2_EXT) begin
              w_brk_n = r_brk;
            end else if (r_brk) begin
              w_brk_n = 1'b0;
            end else begin
              w_keyboard_n = r_shift;
              w_valid_n    = 1'b1;
            end
`else
            w_keyboard_n = r_shift;
            w_valid_n    = 1'b1;
`endif
          end else begin
            w_frame_err_n = 1'b1;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end else if (r_state != IDLE) begin
      if (r_tmo == TMO_LIM) begin
        w_state_n     = IDLE;
        w_tmo_n       = '0;
        w_frame_err_n = 1'b1;
      end else if (r_tmo != TMO_MAX) begin
        w_tmo_n = r_tmo + TMO_W'(1);
      end
    end else begin
      w_tmo_n = '0;
    end
  end

  assign keyboard  = r_keyboard;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Randomised scoreboard bench for ps2_scan_rx.
module tb_ps2_scan_rx;
  import ps2_pkg::*;

  localparam int unsigned FLT  = 8;
  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keyboard;
  logic       valid;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_scan_rx #(
    .FILTER_LEN  (FLT),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keyboard  (keyboard),
    .valid     (valid),
    .frame_err (frame_err)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] kb;
    bit         chk_lat;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned last_fall = 0;
  logic [7:0]  m_kb  = 8'h00;
  bit          m_brk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input bit is_err, input logic [7:0] kb, input bit chk_lat);
    exp_t e;
    e.is_err  = is_err;
    e.kb      = kb;
    e.chk_lat = chk_lat;
    sbq.push_back(e);
  endtask

  // Reference: outcome of one complete frame from its byte and validity
  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      push_exp(1'b1, m_kb, 1'b1);
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_brk = m_brk;
      else if (m_brk) m_brk = 1'b0;
      else begin
        m_kb = b;
        push_exp(1'b0, b, 1'b1);
      end
`else
      m_kb = b;
      push_exp(1'b0, b, 1'b1);
`endif
    end
  endtask

  // One bit cell: data set during high phase, then a low half period
  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(8);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 11);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk   = 1'b0;
    last_fall = cyc;
    wait_cyc(HALF);
    ps2_clk   = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_at);
    logic [10:0] bits;
    logic        par;
    par  = ~(^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    model_frame(b, !bad_par && !bad_stop);
    for (int i = 0; i < 11; i++) send_bit(bits[i], i == glitch_at);
    wait_cyc(10);
  endtask

  // Monitor: every output pulse consumes one expected event
  always @(negedge clk) begin : mon
    exp_t e;
    if (valid || frame_err) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event valid=%0b frame_err=%0b keyboard=%h", valid, frame_err,
                 keyboard);
      end else begin
        e = sbq.pop_front();
        if (valid !== !e.is_err || frame_err !== e.is_err || keyboard !== e.kb) begin
          bad++;
          $display("FAIL event got valid=%0b err=%0b kb=%h want valid=%0b err=%0b kb=%h",
                   valid, frame_err, keyboard, !e.is_err, e.is_err, e.kb);
        end
        if (e.chk_lat) begin
          total++;
          if (cyc - last_fall != FLT + 3) begin
            bad++;
            $display("FAIL latency got=%0d want=%0d", cyc - last_fall, FLT + 3);
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    total++;
    if (keyboard !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL %s got kb=%h valid=%0b err=%0b want all zero", name, keyboard, valid,
               frame_err);
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [10:0] bits;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);
    check_zero("reset_state");

    // Space bar, then the same byte with bad parity
    send_frame(KEY_SPACE, 1'b0, 1'b0, -1);
    send_frame(KEY_SPACE, 1'b1, 1'b0, -1);

    // Partial frame abandoned by timeout, then a clean 0x1C
    push_exp(1'b1, m_kb, 1'b0);
    bits = {2'b11, 8'h1C, 1'b0};
    for (int i = 0; i < 5; i++) send_bit(bits[i], 1'b0);
    wait_cyc(TMO + 20);
    send_frame(8'h1C, 1'b0, 1'b0, -1);

    // Short glitch on ps2_clk inside a bit cell
    send_frame(KEY_SPACE, 1'b0, 1'b0, 4);

    // Break sequence
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    send_frame(KEY_SPACE, 1'b0, 1'b0, -1);
    send_frame(KEY_SPACE, 1'b0, 1'b0, -1);

    // Bad stop bit
    send_frame(8'h5A, 1'b0, 1'b1, -1);

    // Reset after the fifth data bit
    send_frame(8'h29, 1'b0, 1'b0, -1);
    bits = {1'b1, 1'b0, 8'h29, 1'b0};
    for (int i = 0; i < 6; i++) send_bit(bits[i], 1'b0);
    wait_cyc(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_frame_reset");
    m_kb  = 8'h00;
    m_brk = 1'b0;
    push_exp(1'b1, 8'h00, 1'b0);
    for (int i = 6; i < 11; i++) send_bit(bits[i], 1'b0);
    wait_cyc(TMO + 20);
    send_frame(8'h29, 1'b0, 1'b0, -1);

    // Random traffic including prefix codes and framing errors
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      if ($urandom_range(4) == 0) b = ($urandom_range(1) == 0) ? 8'hF0 : 8'hE0;
      send_frame(b, $urandom_range(5) == 0, $urandom_range(7) == 0,
                 ($urandom_range(3) == 0) ? int'($urandom_range(10)) : -1);
    end

    wait_cyc(100);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
